// File: rtl/vc_mux_pkg.sv
// Shared constants for the virtual-channel output multiplexer family.
package vc_mux_pkg;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;
endpackage

// File: rtl/vc_arb_mux_if.sv
// Handshake/bus bundle between the per-VC FIFOs, the mux and the demux stage.
interface vc_arb_mux_if #(
   parameter int DATA_SIZE = 6,
   parameter int NUM_VC    = 2
);
   localparam int VC_W = $clog2(NUM_VC);

   logic [NUM_VC-1:0]           req;
   logic [NUM_VC*DATA_SIZE-1:0] data_in;
   logic                        ready_out;
   logic [NUM_VC-1:0]           pop;
   logic [DATA_SIZE-1:0]        data_out;
   logic [VC_W-1:0]             vc_id_out;
   logic                        valid_out;

   modport master (
      input  req, data_in, ready_out,
      output pop, data_out, vc_id_out, valid_out
   );

   modport slave (
      output req, data_in, ready_out,
      input  pop, data_out, vc_id_out, valid_out
   );
endinterface

// File: rtl/vc_arb_mux_rr_arbiter.sv
// Combinational circular priority search: first set req bit at or after start,
// wrapping NUM_VC-1 -> 0. Returns one-hot grant and its encoded index.
module rr_arbiter #(
   parameter  int NUM_VC = 2,
   localparam int VC_W   = $clog2(NUM_VC)
) (
   input  logic [NUM_VC-1:0] req,
   input  logic [VC_W-1:0]   start,
   output logic [NUM_VC-1:0] gnt,
   output logic [VC_W-1:0]   gnt_idx,
   output logic              any
);
   logic [VC_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < NUM_VC; i++) begin
         idx = VC_W'((32'(start) + i) % NUM_VC);
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end
endmodule

// File: rtl/vc_arb_mux.sv
// N-VC output mux: arbitrates among requesting VCs, pops the winner and
// registers its word behind a valid/ready handshake.
module vc_arb_mux
   import vc_mux_pkg::*;
#(
   parameter int DATA_SIZE = 6,
   parameter int NUM_VC    = 2,
   parameter int MODE      = 1,
   parameter int BURST     = 1
) (
   input logic          clk,
   input logic          reset,
   vc_arb_mux_if.master bus
);
   localparam int VC_W  = $clog2(NUM_VC);
   localparam int CNT_W = $clog2(BURST + 1);
   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
   localparam logic [VC_W-1:0]  LAST_VC = VC_W'(NUM_VC - 1);

   logic [DATA_SIZE-1:0] data_q, data_d;
   logic [VC_W-1:0]      vc_id_q, vc_id_d;
   logic                 valid_q, valid_d;
   logic [VC_W-1:0]      last_gnt_q, last_gnt_d;
   logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;

   logic              slot_free, sticky, any_req, do_pop;
   logic [VC_W-1:0]   start, gnt_idx;
   logic [NUM_VC-1:0] gnt;

   // Continuing a burst is expressed as a search starting at last_gnt itself,
   // which is guaranteed to hit because req[last_gnt] is set.
   always_comb begin
      sticky = (MODE == MODE_RR) && bus.req[last_gnt_q] && (burst_cnt_q < BURST_C);
      if (MODE == MODE_FIXED) begin
         start = '0;
      end else if (sticky) begin
         start = last_gnt_q;
      end else if (last_gnt_q == LAST_VC) begin
         start = '0;
      end else begin
         start = last_gnt_q + VC_W'(1);
      end
   end

   rr_arbiter #(.NUM_VC(NUM_VC)) u_arb (
      .req     (bus.req),
      .start   (start),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any_req)
   );

   always_comb begin
      slot_free   = !valid_q || bus.ready_out;
      do_pop      = slot_free && any_req && !reset;
      bus.pop     = do_pop ? gnt : '0;
      data_d      = data_q;
      vc_id_d     = vc_id_q;
      valid_d     = valid_q;
      last_gnt_d  = last_gnt_q;
      burst_cnt_d = burst_cnt_q;
      if (do_pop) begin
         data_d      = bus.data_in[gnt_idx*DATA_SIZE +: DATA_SIZE];
         vc_id_d     = gnt_idx;
         valid_d     = 1'b1;
         last_gnt_d  = gnt_idx;
         burst_cnt_d = sticky ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
      end else if (bus.ready_out) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q      <= '0;
         vc_id_q     <= '0;
         valid_q     <= 1'b0;
         last_gnt_q  <= LAST_VC;
         burst_cnt_q <= BURST_C;
      end else begin
         data_q      <= data_d;
         vc_id_q     <= vc_id_d;
         valid_q     <= valid_d;
         last_gnt_q  <= last_gnt_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.vc_id_out = vc_id_q;
   assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_vc_arb_mux.sv
// Three mux instances (fixed, round-robin, round-robin burst 2) on shared inputs,
// checked against a rule-level reference model through per-instance scoreboards.
module tb_vc_arb_mux;
   localparam int DW = 6;
   localparam int NV = 4;
   localparam logic [NV*DW-1:0] DIN0 = {6'h13, 6'h12, 6'h11, 6'h10};

   logic              clk = 1'b0;
   logic              reset;
   logic [NV-1:0]     req;
   logic [NV*DW-1:0]  din;
   logic              ready;

   always #5 clk = ~clk;

   vc_arb_mux_if #(.DATA_SIZE(DW), .NUM_VC(NV)) bus0 ();
   vc_arb_mux_if #(.DATA_SIZE(DW), .NUM_VC(NV)) bus1 ();
   vc_arb_mux_if #(.DATA_SIZE(DW), .NUM_VC(NV)) bus2 ();

   assign bus0.req = req;  assign bus0.data_in = din;  assign bus0.ready_out = ready;
   assign bus1.req = req;  assign bus1.data_in = din;  assign bus1.ready_out = ready;
   assign bus2.req = req;  assign bus2.data_in = din;  assign bus2.ready_out = ready;

   vc_arb_mux #(.DATA_SIZE(DW), .NUM_VC(NV), .MODE(0), .BURST(1))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));
   vc_arb_mux #(.DATA_SIZE(DW), .NUM_VC(NV), .MODE(1), .BURST(1))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));
   vc_arb_mux #(.DATA_SIZE(DW), .NUM_VC(NV), .MODE(1), .BURST(2))
      dut2 (.clk(clk), .reset(reset), .bus(bus2));

   logic [NV-1:0] pop_a  [3];
   logic [DW-1:0] dout_a [3];
   logic [1:0]    id_a   [3];
   logic          val_a  [3];

   assign pop_a[0] = bus0.pop;  assign dout_a[0] = bus0.data_out;
   assign id_a[0]  = bus0.vc_id_out;  assign val_a[0] = bus0.valid_out;
   assign pop_a[1] = bus1.pop;  assign dout_a[1] = bus1.data_out;
   assign id_a[1]  = bus1.vc_id_out;  assign val_a[1] = bus1.valid_out;
   assign pop_a[2] = bus2.pop;  assign dout_a[2] = bus2.data_out;
   assign id_a[2]  = bus2.vc_id_out;  assign val_a[2] = bus2.valid_out;

   typedef struct {
      logic [DW-1:0] d;
      int            id;
   } exp_t;

   int   mode_p  [3] = '{0, 1, 1};
   int   burst_p [3] = '{1, 1, 2};
   int   m_last  [3];
   int   m_cnt   [3];
   bit   m_valid [3];
   exp_t sb [3][$];

   int n_chk  = 0;
   int n_pass = 0;

   function automatic void chk(string name, int k, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
   endfunction

   // Grant chosen from the arbitration rules applied to the current request vector.
   function automatic int ref_grant(int k, logic [NV-1:0] r);
      if (mode_p[k] == 0) begin
         for (int i = 0; i < NV; i++) if (r[i]) return i;
         return -1;
      end
      if (r[m_last[k]] && m_cnt[k] < burst_p[k]) return m_last[k];
      for (int i = 1; i <= NV; i++) begin
         int j = (m_last[k] + i) % NV;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_last[k]  = NV - 1;
         m_cnt[k]   = burst_p[k];
         m_valid[k] = 1'b0;
         sb[k].delete();
      end
   endfunction

   task automatic cycle(input logic [NV-1:0] r, input logic rdy, input logic [NV*DW-1:0] d);
      @(negedge clk);
      req = r; ready = rdy; din = d;
      #1;
      for (int k = 0; k < 3; k++) begin
         logic [NV-1:0] exp_pop;
         exp_t          e;
         int            g;
         bit            cont;
         exp_pop = '0;
         chk("valid_out", k, val_a[k], m_valid[k]);
         if ((!m_valid[k] || rdy) && r != '0) begin
            g       = ref_grant(k, r);
            cont    = r[m_last[k]] && m_cnt[k] < burst_p[k];
            exp_pop = NV'(1 << g);
            e.d     = d[g*DW +: DW];
            e.id    = g;
            sb[k].push_back(e);
            m_cnt[k]   = cont ? m_cnt[k] + 1 : 1;
            m_last[k]  = g;
            m_valid[k] = 1'b1;
         end else if (rdy) begin
            m_valid[k] = 1'b0;
         end
         chk("pop", k, pop_a[k], exp_pop);
      end
   endtask

   // Asynchronous reset mid-cycle; outputs must clear with no clock edge.
   task automatic do_reset();
      @(negedge clk);
      #3;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_valid", k, val_a[k], 0);
         chk("rst_data",  k, dout_a[k], 0);
         chk("rst_id",    k, id_a[k], 0);
         chk("rst_pop",   k, pop_a[k], 0);
      end
      req   = '0;
      ready = 1'b1;
      model_reset();
      @(negedge clk);
      #3;
      reset = 1'b0;
   endtask

   // Monitor: whenever an instance presents valid data, it must match the head
   // of its scoreboard; the head retires when the word is accepted.
   always @(negedge clk) begin
      #2;
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            if (val_a[k]) begin
               chk("sb_nonempty", k, sb[k].size() > 0, 1);
               if (sb[k].size() > 0) begin
                  chk("data_out",  k, dout_a[k], sb[k][0].d);
                  chk("vc_id_out", k, id_a[k],   sb[k][0].id);
                  if (ready) void'(sb[k].pop_front());
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      req   = '0;
      ready = 1'b1;
      din   = DIN0;
      model_reset();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("init_valid", k, val_a[k], 0);
         chk("init_pop",   k, pop_a[k], 0);
      end
      @(negedge clk);
      #3;
      reset = 1'b0;

      // Fixed priority picks VC1 from 4'b1010.
      cycle(4'b1010, 1'b1, DIN0);
      chk("mode0_pop", 0, pop_a[0], 4'b0010);
      cycle(4'b0000, 1'b1, DIN0);
      chk("mode0_data", 0, dout_a[0], 6'h11);
      chk("mode0_id",   0, id_a[0], 1);

      // Full request: round-robin rotation and burst-of-two, then drop VC2.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1, DIN0);
      cycle(4'b1011, 1'b1, DIN0);
      cycle(4'b1011, 1'b1, DIN0);

      // Backpressure holds output and suppresses pop.
      do_reset();
      cycle(4'b0100, 1'b1, DIN0);
      for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b0, DIN0);
      cycle(4'b0100, 1'b1, DIN0);
      chk("bp_release_pop", 0, pop_a[0], 4'b0100);
      cycle(4'b0000, 1'b1, DIN0);
      chk("bp_data", 0, dout_a[0], 6'h12);

      // Wrap from VC3 to VC0, idle, then sparse request.
      do_reset();
      cycle(4'b1000, 1'b1, DIN0);
      cycle(4'b0001, 1'b1, DIN0);
      cycle(4'b0000, 1'b1, DIN0);
      cycle(4'b0000, 1'b1, DIN0);
      cycle(4'b0011, 1'b1, DIN0);
      cycle(4'b0011, 1'b1, DIN0);
      cycle(4'b0000, 1'b1, DIN0);

      // Randomized traffic with random backpressure and occasional reset.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 75) do_reset();
         cycle(NV'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
               (NV*DW)'({$urandom, $urandom}));
      end
      cycle(4'b0000, 1'b1, DIN0);
      cycle(4'b0000, 1'b1, DIN0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
